alu_sequencer: RTL

- Issuing side of the 16-bit ALU interface. Accepts an operation request (function select plus two operands) over a ready/valid handshake.
- Drives the ALU's operand buses and 4-bit Control code, then captures the ALU's WriteData one cycle later.
- Computes signed overflow locally for ADD/SUB and keeps a sticky overflow status.
- Sits between the datapath/controller and the ALU, which evaluates on the falling clock edge.

---
 rtl/alu_sequencer_if.sv | 40 ++++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU and status signals of the ALU sequencer.
//   master : requester plus ALU side (drives request, ovf_clr and WriteData)
//   slave  : the sequencer (drives req_ready, operand buses, Control, status)
// Signals:
//   req_valid/req_ready/req_func/req_a/req_b/fwd_a : request handshake
//   ReadData1/ReadData2/Control/WriteData          : ALU operand/result buses
//   done/result/ovf/err/ovf_sticky/ovf_clr         : completion and status
interface alu_sequencer_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CTRL_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_func;
  logic [WIDTH-1:0]  req_a;
  logic [WIDTH-1:0]  req_b;
  logic              fwd_a;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic [CTRL_W-1:0] Control;
  logic [WIDTH-1:0]  WriteData;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              ovf;
  logic              err;
  logic              ovf_sticky;
  logic              ovf_clr;

  modport master (
    output req_valid, req_func, req_a, req_b, fwd_a, ovf_clr, WriteData,
    input  req_ready, ReadData1, ReadData2, Control, done, result, ovf, err,
           ovf_sticky
  );

  modport slave (
    input  req_valid, req_func, req_a, req_b, fwd_a, ovf_clr, WriteData,
    output req_ready, ReadData1, ReadData2, Control, done, result, ovf, err,
           ovf_sticky
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one operation at a time to a falling-edge 16-bit ALU.
// Accepts a request in IDLE, drives operands and Control during EXEC, then
// captures WriteData, reports done/ovf/err and keeps a sticky overflow flag.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : alu_sequencer_if.slave (request, ALU buses, status)
// Optional feature: define ALU_SEQ_FWD_EN to let fwd_a load ReadData1 from the
// current result register (chained operations). Undefined: fwd_a is ignored.
module alu_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_sequencer_if.slave       bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam logic [2:0] F_AND = 3'd0;
  localparam logic [2:0] F_OR  = 3'd1;
  localparam logic [2:0] F_ADD = 3'd2;
  localparam logic [2:0] F_SUB = 3'd3;
  localparam logic [2:0] F_SLT = 3'd4;
  localparam logic [2:0] F_NOR = 3'd5;

  // Function select to ALU Control code; illegal codes never reach Control.
  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [2:0] f);
    case (f)
      F_AND:   ctrl_of = CTRL_W'(4'b0000);
      F_OR:    ctrl_of = CTRL_W'(4'b0001);
      F_ADD:   ctrl_of = CTRL_W'(4'b0010);
      F_SUB:   ctrl_of = CTRL_W'(4'b0110);
      F_SLT:   ctrl_of = CTRL_W'(4'b0111);
      F_NOR:   ctrl_of = CTRL_W'(4'b1100);
      default: ctrl_of = '0;
    endcase
  endfunction

  logic [0:0]        state_q,  state_nxt;
  logic              rdy_q,    rdy_nxt;
  logic [2:0]        func_q,   func_nxt;
  logic [WIDTH-1:0]  rd1_q,    rd1_nxt;
  logic [WIDTH-1:0]  rd2_q,    rd2_nxt;
  logic [CTRL_W-1:0] ctrl_q,   ctrl_nxt;
  logic              done_q,   done_nxt;
  logic [WIDTH-1:0]  result_q, result_nxt;
  logic              ovf_q,    ovf_nxt;
  logic              err_q,    err_nxt;
  logic              sticky_q, sticky_nxt;

  logic [WIDTH-1:0]  opa_c;
  logic              req_legal_c;
  logic              exec_legal_c;
  logic              ovf_c;

  // Operand A source: forwarded result or the request operand.
`ifdef ALU_SEQ_FWD_EN
  assign opa_c = bus.fwd_a ? result_q : bus.req_a;
`else
  logic fwd_unused;
  assign fwd_unused = bus.fwd_a;
  assign opa_c      = bus.req_a;
`endif

  assign req_legal_c  = (bus.req_func <= F_NOR);
  assign exec_legal_c = (func_q <= F_NOR);

  // Signed overflow from the registered operands and the ALU's result.
  always_comb begin
    ovf_c = 1'b0;
    case (func_q)
      F_ADD: ovf_c = (rd1_q[WIDTH-1] == rd2_q[WIDTH-1]) &&
                     (bus.WriteData[WIDTH-1] != rd1_q[WIDTH-1]);
      F_SUB: ovf_c = (rd1_q[WIDTH-1] != rd2_q[WIDTH-1]) &&
                     (bus.WriteData[WIDTH-1] != rd1_q[WIDTH-1]);
      default: ovf_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt  = state_q;
    rdy_nxt    = rdy_q;
    func_nxt   = func_q;
    rd1_nxt    = rd1_q;
    rd2_nxt    = rd2_q;
    ctrl_nxt   = ctrl_q;
    done_nxt   = 1'b0;
    ovf_nxt    = 1'b0;
    err_nxt    = 1'b0;
    result_nxt = result_q;
    sticky_nxt = bus.ovf_clr ? 1'b0 : sticky_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt = ST_EXEC;
          rdy_nxt   = 1'b0;
          func_nxt  = bus.req_func;
          // Illegal functions leave the ALU buses untouched.
          if (req_legal_c) begin
            rd1_nxt  = opa_c;
            rd2_nxt  = bus.req_b;
            ctrl_nxt = ctrl_of(bus.req_func);
          end
        end
      end
      ST_EXEC: begin
        state_nxt  = ST_IDLE;
        rdy_nxt    = 1'b1;
        done_nxt   = 1'b1;
        err_nxt    = ~exec_legal_c;
        result_nxt = exec_legal_c ? bus.WriteData : '0;
        ovf_nxt    = ovf_c;
        // A new overflow takes priority over a simultaneous clear.
        if (ovf_c) sticky_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
        rdy_nxt   = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b1;
      func_q   <= F_AND;
      rd1_q    <= '0;
      rd2_q    <= '0;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      rdy_q    <= rdy_nxt;
      func_q   <= func_nxt;
      rd1_q    <= rd1_nxt;
      rd2_q    <= rd2_nxt;
      ctrl_q   <= ctrl_nxt;
      done_q   <= done_nxt;
      result_q <= result_nxt;
      ovf_q    <= ovf_nxt;
      err_q    <= err_nxt;
      sticky_q <= sticky_nxt;
    end
  end

  assign bus.req_ready  = rdy_q;
  assign bus.ReadData1  = rd1_q;
  assign bus.ReadData2  = rd2_q;
  assign bus.Control    = ctrl_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.ovf        = ovf_q;
  assign bus.err        = err_q;
  assign bus.ovf_sticky = sticky_q;

endmodule
